// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA stage: walks the KSA-permuted S RAM, XORs the keystream with the encrypted ROM
// and writes plaintext to the decrypted RAM. Optional printable-text check: PRGA_ASCII_CHECK_EN.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int RD_LAT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       done_flag,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] enc_addr,
    input  logic [7:0] enc_rddata,
    output logic [7:0] dec_addr,
    output logic [7:0] dec_wrdata,
    output logic       dec_wren
`ifdef PRGA_ASCII_CHECK_EN
    ,
    output logic       key_invalid
`endif
);

    typedef enum logic [3:0] {
        IDLE, RD_I, WAIT_I, SAVE_I, RD_J, WAIT_J, SAVE_J,
        WR_I, WR_J, RD_F, WAIT_F, SAVE_F, WR_DEC, DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST = (RD_LAT > 0) ? 8'(RD_LAT - 1) : 8'd0;
    localparam logic [8:0] LAST_K    = 9'(MSG_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt;
    logic       wait_done, in_wait, abort;
    logic [7:0] i, j, si, sj, f;
    logic [8:0] k;
    logic [7:0] plain_byte;

    assign plain_byte = s_rddata ^ enc_rddata;
    assign in_wait    = (state_q == WAIT_I) || (state_q == WAIT_J) || (state_q == WAIT_F);
    assign wait_done  = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
        end else if (start) begin
            state_q  <= state_d;
            wait_cnt <= (in_wait && !wait_done) ? wait_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RD_I;
            RD_I:    state_d = (RD_LAT == 0) ? SAVE_I : WAIT_I;
            WAIT_I:  if (wait_done) state_d = SAVE_I;
            SAVE_I:  state_d = RD_J;
            RD_J:    state_d = (RD_LAT == 0) ? SAVE_J : WAIT_J;
            WAIT_J:  if (wait_done) state_d = SAVE_J;
            SAVE_J:  state_d = WR_I;
            WR_I:    state_d = WR_J;
            WR_J:    state_d = RD_F;
            RD_F:    state_d = (RD_LAT == 0) ? SAVE_F : WAIT_F;
            WAIT_F:  if (wait_done) state_d = SAVE_F;
            SAVE_F:  state_d = WR_DEC;
            WR_DEC:  state_d = (k == LAST_K || abort) ? DONE : RD_I;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Swap operands and the decrypted byte carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (start) begin
            if (state_q == SAVE_I) si <= s_rddata;
            if (state_q == SAVE_J) sj <= s_rddata;
            if (state_q == SAVE_F) f  <= plain_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i          <= '0;
            j          <= '0;
            k          <= '0;
            s_addr     <= '0;
            s_wrdata   <= '0;
            s_wren     <= 1'b0;
            enc_addr   <= '0;
            dec_addr   <= '0;
            dec_wrdata <= '0;
            dec_wren   <= 1'b0;
            done_flag  <= 1'b0;
        end else if (start) begin
            dec_wren <= 1'b0;
            case (state_q)
                RD_I: begin
                    i      <= i + 8'd1;
                    s_addr <= i + 8'd1;
                    s_wren <= 1'b0;
                end
                SAVE_I: j <= j + s_rddata;
                RD_J:   s_addr <= j;
                WR_I: begin
                    s_addr   <= i;
                    s_wrdata <= sj;
                    s_wren   <= 1'b1;
                end
                WR_J: begin
                    s_addr   <= j;
                    s_wrdata <= si;
                    s_wren   <= 1'b1;
                end
                RD_F: begin
                    s_wren   <= 1'b0;
                    s_addr   <= si + sj;
                    enc_addr <= k[7:0];
                end
                WR_DEC: begin
                    dec_addr   <= k[7:0];
                    dec_wrdata <= f;
                    dec_wren   <= 1'b1;
                    k          <= k + 9'd1;
                end
                DONE: begin
                    s_wren    <= 1'b0;
                    done_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PRGA_ASCII_CHECK_EN
    function automatic logic ascii_ok(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
    endfunction

    // A non-text byte is still written out, then the run stops with key_invalid raised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abort       <= 1'b0;
            key_invalid <= 1'b0;
        end else if (start) begin
            if (state_q == SAVE_F) abort <= !ascii_ok(plain_byte);
            if (state_q == WR_DEC && abort) key_invalid <= 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt: three instances (MSG_LEN 9, 2, 256) with RAM/ROM models
// whose read data arrives two cycles after the address, matching RD_LAT=2.
`timescale 1ns/1ps
module tb_rc4_prga_decrypt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [2:0] start = 3'b000;
    logic [2:0] done_flag, s_wren, dec_wren;
    logic [2:0][7:0] s_addr, s_rddata, s_wrdata, enc_addr, enc_rddata, dec_addr, dec_wrdata;
    logic [2:0][7:0] s_q0, enc_q0;
`ifdef PRGA_ASCII_CHECK_EN
    logic [2:0] key_invalid;
`endif

    logic [7:0] s_mem   [3][256];
    logic [7:0] enc_mem [3][256];
    logic [7:0] dec_mem [3][256];
    logic [7:0] img [256];

    logic       ld_we   = 1'b0;
    int         ld_inst = 0;
    int         ld_sel  = 0;
    logic [7:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] CIPHER [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    localparam logic [7:0] PLAIN  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LEN = (g == 0) ? 9 : ((g == 1) ? 2 : 256);
        rc4_prga_decrypt #(.MSG_LEN(LEN), .RD_LAT(2)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .done_flag  (done_flag[g]),
            .s_addr     (s_addr[g]),
            .s_rddata   (s_rddata[g]),
            .s_wrdata   (s_wrdata[g]),
            .s_wren     (s_wren[g]),
            .enc_addr   (enc_addr[g]),
            .enc_rddata (enc_rddata[g]),
            .dec_addr   (dec_addr[g]),
            .dec_wrdata (dec_wrdata[g]),
            .dec_wren   (dec_wren[g])
`ifdef PRGA_ASCII_CHECK_EN
            ,
            .key_invalid(key_invalid[g])
`endif
        );
    end

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (s_wren[g]) s_mem[g][s_addr[g]] <= s_wrdata[g];
            if (dec_wren[g]) dec_mem[g][dec_addr[g]] <= dec_wrdata[g];
            s_q0[g]       <= s_mem[g][s_addr[g]];
            s_rddata[g]   <= s_q0[g];
            enc_q0[g]     <= enc_mem[g][enc_addr[g]];
            enc_rddata[g] <= enc_q0[g];
        end
        if (ld_we) begin
            case (ld_sel)
                0:       s_mem[ld_inst][ld_addr]   <= ld_data;
                1:       enc_mem[ld_inst][ld_addr] <= ld_data;
                default: dec_mem[ld_inst][ld_addr] <= ld_data;
            endcase
        end
    end

    function automatic logic [42:0] out_vec(input int g);
        return {done_flag[g], s_addr[g], s_wrdata[g], s_wren[g], enc_addr[g],
                dec_addr[g], dec_wrdata[g], dec_wren[g]};
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int a = 0; a < 256; a++) img[a] = v;
    endtask

    task automatic fill_ident;
        for (int a = 0; a < 256; a++) img[a] = 8'(a);
    endtask

    task automatic fill_cipher;
        fill_const(8'h00);
        for (int a = 0; a < 9; a++) img[a] = CIPHER[a];
    endtask

    task automatic fill_ksa;
        logic [7:0] key [3];
        logic [7:0] jj, t;
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
        fill_ident();
        jj = 8'h00;
        for (int a = 0; a < 256; a++) begin
            jj = jj + img[a] + key[a % 3];
            t = img[a]; img[a] = img[jj]; img[jj] = t;
        end
    endtask

    task automatic load(input int inst, input int sel);
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_inst = inst; ld_sel = sel; ld_addr = 8'(a); ld_data = img[a];
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic pulse_reset;
        @(posedge clk); #1;
        start = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // cycles counts clock edges after the edge on which the block first sees start high.
    task automatic run_inst(input int inst, input int stall_at, input int stall_len,
                            input int limit, output int cycles, output int wr_cnt);
        cycles = 0;
        wr_cnt = 0;
        @(posedge clk); #1;
        start[inst] = 1'b1;
        @(posedge clk); #1;
        while (cycles < limit && !done_flag[inst]) begin
            @(posedge clk); #1;
            cycles++;
            if (dec_wren[inst]) wr_cnt++;
            if (cycles == stall_at) begin
                start[inst] = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    cycles++;
                end
                start[inst] = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if (out_vec(g) !== 43'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got %h, expected 0", g, out_vec(g));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_identity;
        int cyc, wr;
        fill_ident();      load(1, 0);
        fill_const(8'h00); load(1, 1);
        fill_const(8'hEE); load(1, 2);
        run_inst(1, -1, 0, 200, cyc, wr);
        n_tests++;
        if (cyc !== 31) begin n_fail++; $display("FAIL ident_latency: got %0d, expected 31", cyc); end
        n_tests++;
        if (wr !== 2) begin n_fail++; $display("FAIL ident_writes: got %0d, expected 2", wr); end
        n_tests++;
        if (dec_mem[1][0] !== 8'h02) begin n_fail++; $display("FAIL ident_dec0: got %h, expected 02", dec_mem[1][0]); end
        n_tests++;
        if (dec_mem[1][1] !== 8'h05) begin n_fail++; $display("FAIL ident_dec1: got %h, expected 05", dec_mem[1][1]); end
        n_tests++;
        if (s_mem[1][2] !== 8'h03) begin n_fail++; $display("FAIL ident_s2: got %h, expected 03", s_mem[1][2]); end
        n_tests++;
        if (s_mem[1][3] !== 8'h02) begin n_fail++; $display("FAIL ident_s3: got %h, expected 02", s_mem[1][3]); end
        n_tests++;
        if (dec_mem[1][2] !== 8'hEE) begin n_fail++; $display("FAIL ident_dec2_untouched: got %h, expected ee", dec_mem[1][2]); end
    endtask

    task automatic test_plaintext;
        int cyc, wr;
        fill_ksa();        load(0, 0);
        fill_cipher();     load(0, 1);
        fill_const(8'hEE); load(0, 2);
        run_inst(0, -1, 0, 400, cyc, wr);
        n_tests++;
        if (cyc !== 136) begin n_fail++; $display("FAIL plain_latency: got %0d, expected 136", cyc); end
        n_tests++;
        if (wr !== 9) begin n_fail++; $display("FAIL plain_writes: got %0d, expected 9", wr); end
        for (int a = 0; a < 9; a++) begin
            n_tests++;
            if (dec_mem[0][a] !== PLAIN[a]) begin
                n_fail++;
                $display("FAIL plain_dec[%0d]: got %h, expected %h", a, dec_mem[0][a], PLAIN[a]);
            end
        end
    endtask

    task automatic test_stall;
        int cyc, wr;
        pulse_reset();
        fill_ksa();        load(0, 0);
        fill_const(8'hEE); load(0, 2);
        run_inst(0, 65, 20, 400, cyc, wr);
        n_tests++;
        if (cyc !== 156) begin n_fail++; $display("FAIL stall_latency: got %0d, expected 156", cyc); end
        for (int a = 0; a < 9; a++) begin
            n_tests++;
            if (dec_mem[0][a] !== PLAIN[a]) begin
                n_fail++;
                $display("FAIL stall_dec[%0d]: got %h, expected %h", a, dec_mem[0][a], PLAIN[a]);
            end
        end
    endtask

    task automatic test_reset_midrun;
        int cyc, wr;
        pulse_reset();
        fill_ksa();        load(0, 0);
        fill_const(8'hEE); load(0, 2);
        @(posedge clk); #1;
        start[0] = 1'b1;
        repeat (25) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (out_vec(0) !== 43'd0) begin n_fail++; $display("FAIL midrun_reset_outputs: got %h, expected 0", out_vec(0)); end
        rst_n = 1'b1;
        start[0] = 1'b0;
        fill_ksa();        load(0, 0);
        fill_const(8'hEE); load(0, 2);
        run_inst(0, -1, 0, 400, cyc, wr);
        n_tests++;
        if (cyc !== 136) begin n_fail++; $display("FAIL rerun_latency: got %0d, expected 136", cyc); end
        for (int a = 0; a < 9; a++) begin
            n_tests++;
            if (dec_mem[0][a] !== PLAIN[a]) begin
                n_fail++;
                $display("FAIL rerun_dec[%0d]: got %h, expected %h", a, dec_mem[0][a], PLAIN[a]);
            end
        end
    endtask

    task automatic test_wrap_256;
        int cyc, wr;
        logic [255:0] seen;
        fill_ident();      load(2, 0);
        fill_const(8'h00); load(2, 1);
        fill_const(8'hEE); load(2, 2);
        run_inst(2, -1, 0, 5000, cyc, wr);
        n_tests++;
        if (cyc !== 3841) begin n_fail++; $display("FAIL wrap_latency: got %0d, expected 3841", cyc); end
        n_tests++;
        if (wr !== 256) begin n_fail++; $display("FAIL wrap_writes: got %0d, expected 256", wr); end
        n_tests++;
        if (dec_addr[2] !== 8'hFF) begin n_fail++; $display("FAIL wrap_last_addr: got %h, expected ff", dec_addr[2]); end
        n_tests++;
        if (dec_mem[2][0] !== 8'h02) begin n_fail++; $display("FAIL wrap_dec0: got %h, expected 02", dec_mem[2][0]); end
        n_tests++;
        if (dec_mem[2][1] !== 8'h05) begin n_fail++; $display("FAIL wrap_dec1: got %h, expected 05", dec_mem[2][1]); end
        seen = '0;
        for (int a = 0; a < 256; a++) seen[s_mem[2][a]] = 1'b1;
        n_tests++;
        if (seen !== {256{1'b1}}) begin n_fail++; $display("FAIL wrap_s_permutation: got %h, expected all ones", seen); end
    endtask

`ifdef PRGA_ASCII_CHECK_EN
    task automatic test_ascii;
        int cyc, wr;
        pulse_reset();
        fill_ksa();        load(0, 0);
        fill_cipher();     load(0, 1);
        fill_const(8'hEE); load(0, 2);
        run_inst(0, -1, 0, 400, cyc, wr);
        n_tests++;
        if (cyc !== 16) begin n_fail++; $display("FAIL ascii_latency: got %0d, expected 16", cyc); end
        n_tests++;
        if (key_invalid[0] !== 1'b1) begin n_fail++; $display("FAIL ascii_key_invalid: got %b, expected 1", key_invalid[0]); end
        n_tests++;
        if (wr !== 1) begin n_fail++; $display("FAIL ascii_writes: got %0d, expected 1", wr); end
        n_tests++;
        if (dec_mem[0][0] !== 8'h50) begin n_fail++; $display("FAIL ascii_dec0: got %h, expected 50", dec_mem[0][0]); end
        n_tests++;
        if (dec_mem[0][1] !== 8'hEE) begin n_fail++; $display("FAIL ascii_dec1_untouched: got %h, expected ee", dec_mem[0][1]); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PRGA_ASCII_CHECK_EN
        test_ascii();
`else
        test_identity();
        test_plaintext();
        test_stall();
        test_reset_midrun();
        test_wrap_256();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
